// File: rtl/decode_if.sv
// Fetch/writeback-to-decode bus: instruct word plus register write port in, decoded operands and control out.
interface decode_if;
  logic [32:0] instruct;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dec_valid;
  logic [3:0]  alu_sel;
  logic        use_imm;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  wr_addr;
  logic [4:0]  shamt;
  logic [31:0] imm_ext;
  logic        halt;
  logic        illegal;

  modport master (
    output instruct, wb_en, wb_addr, wb_data,
    input  dec_valid, alu_sel, use_imm, reg_we, mem_rd, mem_wr,
           rs_data, rt_data, wr_addr, shamt, imm_ext, halt, illegal
  );

  modport slave (
    input  instruct, wb_en, wb_addr, wb_data,
    output dec_valid, alu_sel, use_imm, reg_we, mem_rd, mem_wr,
           rs_data, rt_data, wr_addr, shamt, imm_ext, halt, illegal
  );
endinterface

// File: rtl/decode.sv
// Decode stage: tracks the fetch cadence, captures one word per CYCLES clocks, decodes it and reads the register file.
// Latency: outputs registered on the capture edge; no backpressure, the cadence is fixed and only a flush re-aligns it.
module decode #(
  parameter int CYCLES   = 5,
  parameter bit REG_INIT = 1'b1
) (
  input logic     clk,
  input logic     clr,
  decode_if.slave bus
);
  localparam int PW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(CYCLES - 1);

  typedef enum logic [1:0] {SYNC, RUN, HALT} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [31:0]   regs [32];

  logic        dec_valid_q, use_imm_q, reg_we_q, mem_rd_q, mem_wr_q, halt_q, illegal_q;
  logic [3:0]  alu_sel_q;
  logic [4:0]  wr_addr_q, shamt_q;
  logic [31:0] rs_data_q, rt_data_q, imm_ext_q;

  logic [3:0]  d_alu;
  logic [4:0]  d_wa;
  logic        d_imm, d_we, d_rd, d_wr, d_ill, d_halt, r_type;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_val, rt_val;

  assign rs_addr = bus.instruct[25:21];
  assign rt_addr = bus.instruct[20:16];

  always_comb begin
    d_alu  = 4'd0;
    d_wa   = 5'd0;
    d_imm  = 1'b0;
    d_we   = 1'b0;
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    d_ill  = 1'b0;
    d_halt = 1'b0;
    r_type = 1'b0;
    case (bus.instruct[31:26])
      6'b000000: r_type = 1'b1;
      6'b000001: begin r_type = 1'b1; d_alu = 4'd1; end
      6'b000101: begin r_type = 1'b1; d_alu = 4'd2; end
      6'b000110: begin r_type = 1'b1; d_alu = 4'd3; end
      6'b000111: begin r_type = 1'b1; d_alu = 4'd4; end
      6'b000011: begin r_type = 1'b1; d_alu = 4'd5; end
      6'b000100: begin r_type = 1'b1; d_alu = 4'd6; end
      6'b001011: begin d_imm = 1'b1; d_we = 1'b1; d_wa = rt_addr; end
      6'b000010: begin d_alu = 4'd7; d_imm = 1'b1; d_we = 1'b1; d_wa = rt_addr; end
      6'b100011: begin d_imm = 1'b1; d_rd = 1'b1; d_we = 1'b1; d_wa = rt_addr; end
      6'b101011: begin d_imm = 1'b1; d_wr = 1'b1; end
      6'b111111: d_halt = 1'b1;
      default:   d_ill = 1'b1;
    endcase
    if (r_type) begin
      d_we = 1'b1;
      d_wa = bus.instruct[15:11];
    end
  end

  // A write landing on the capture edge must be visible to the instruction captured on it.
  assign rs_val = (bus.wb_en && bus.wb_addr == rs_addr && rs_addr != 5'd0) ? bus.wb_data : regs[rs_addr];
  assign rt_val = (bus.wb_en && bus.wb_addr == rt_addr && rt_addr != 5'd0) ? bus.wb_data : regs[rt_addr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= REG_INIT ? 32'(i) : 32'd0;
    end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= SYNC;
      phase       <= '0;
      dec_valid_q <= 1'b0;
      alu_sel_q   <= 4'd0;
      use_imm_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      wr_addr_q   <= 5'd0;
      shamt_q     <= 5'd0;
      imm_ext_q   <= 32'd0;
      halt_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      dec_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (bus.instruct[32]) begin
        state  <= RUN;
        phase  <= '0;
        halt_q <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (phase == LAST) begin
              phase       <= '0;
              dec_valid_q <= 1'b1;
              alu_sel_q   <= d_alu;
              use_imm_q   <= d_imm;
              reg_we_q    <= d_we;
              mem_rd_q    <= d_rd;
              mem_wr_q    <= d_wr;
              rs_data_q   <= rs_val;
              rt_data_q   <= rt_val;
              wr_addr_q   <= d_wa;
              shamt_q     <= bus.instruct[10:6];
              imm_ext_q   <= {{16{bus.instruct[15]}}, bus.instruct[15:0]};
              illegal_q   <= d_ill;
              if (d_halt) begin
                halt_q <= 1'b1;
                state  <= HALT;
              end
            end else begin
              phase <= phase + PW'(1);
            end
          end
          default: phase <= '0;
        endcase
      end
    end
  end

  assign bus.dec_valid = dec_valid_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.use_imm   = use_imm_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.rs_data   = rs_data_q;
  assign bus.rt_data   = rt_data_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.shamt     = shamt_q;
  assign bus.imm_ext   = imm_ext_q;
  assign bus.halt      = halt_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_decode.sv
// Bench for decode: hand-written vector table plus random instructions against a register-file model.
module tb_decode;
  logic clk = 1'b0;
  logic clr = 1'b1;

  decode_if bus ();

  decode #(.CYCLES(5), .REG_INIT(1'b1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       imm;
    logic       we;
    logic       rd;
    logic       wr;
    logic       ill;
    logic       hlt;
    logic [4:0] wa;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] w;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] mreg [32];
  bit rnd_wb = 1'b0;
  vec_t vt [12];

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh);
    return {op, rs, rt, rd, sh, 6'h2A};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t ex(input int alu, input bit imm, input bit we, input bit rd, input bit wr,
                              input bit ill, input bit hlt, input int wa);
    exp_t e;
    e.alu = 4'(alu); e.imm = imm; e.we = we; e.rd = rd; e.wr = wr;
    e.ill = ill; e.hlt = hlt; e.wa = 5'(wa);
    return e;
  endfunction

  function automatic vec_t mkv(input string nm, input logic [31:0] w, input exp_t e);
    vec_t v;
    v.name = nm; v.w = w; v.e = e;
    return v;
  endfunction

  // Reference decode straight from the opcode table.
  function automatic exp_t ref_dec(input logic [31:0] w);
    int rd = int'(w[15:11]);
    int rt = int'(w[20:16]);
    case (w[31:26])
      6'b000000: return ex(0, 0, 1, 0, 0, 0, 0, rd);
      6'b000001: return ex(1, 0, 1, 0, 0, 0, 0, rd);
      6'b000101: return ex(2, 0, 1, 0, 0, 0, 0, rd);
      6'b000110: return ex(3, 0, 1, 0, 0, 0, 0, rd);
      6'b000111: return ex(4, 0, 1, 0, 0, 0, 0, rd);
      6'b000011: return ex(5, 0, 1, 0, 0, 0, 0, rd);
      6'b000100: return ex(6, 0, 1, 0, 0, 0, 0, rd);
      6'b001011: return ex(0, 1, 1, 0, 0, 0, 0, rt);
      6'b000010: return ex(7, 1, 1, 0, 0, 0, 0, rt);
      6'b100011: return ex(0, 1, 1, 1, 0, 0, 0, rt);
      6'b101011: return ex(0, 1, 0, 0, 1, 0, 0, 0);
      6'b111111: return ex(0, 0, 0, 0, 0, 0, 1, 0);
      default:   return ex(0, 0, 0, 0, 0, 1, 0, 0);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.wb_en && bus.wb_addr != 5'd0) mreg[bus.wb_addr] = bus.wb_data;
  endtask

  task automatic rand_wb();
    bus.wb_en   = rnd_wb ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.wb_addr = 5'($urandom());
    bus.wb_data = $urandom();
  endtask

  task automatic do_flush();
    bus.instruct = {1'b1, 32'($urandom())};
    rand_wb();
    step();
    bus.instruct[32] = 1'b0;
    chk("flush_dv", 32'(bus.dec_valid), 32'd0);
    chk("flush_halt", 32'(bus.halt), 32'd0);
  endtask

  // Garbage on the word for four edges, real word only across the capture edge.
  task automatic issue(input logic [31:0] w, input exp_t e, input bit cw_en, input logic [4:0] cw_addr,
                       input logic [31:0] cw_data, input string nm);
    for (int i = 0; i < 4; i++) begin
      bus.instruct = {1'b0, 32'($urandom())};
      rand_wb();
      step();
      chk({nm, "_gap_dv"}, 32'(bus.dec_valid), 32'd0);
    end
    bus.instruct = {1'b0, w};
    bus.wb_en    = cw_en;
    bus.wb_addr  = cw_addr;
    bus.wb_data  = cw_data;
    step();
    bus.wb_en = 1'b0;
    if (!e.hlt) chk({nm, "_dv"}, 32'(bus.dec_valid), 32'd1);
    chk({nm, "_alu"}, 32'(bus.alu_sel), 32'(e.alu));
    chk({nm, "_imm"}, 32'(bus.use_imm), 32'(e.imm));
    chk({nm, "_we"}, 32'(bus.reg_we), 32'(e.we));
    chk({nm, "_rd"}, 32'(bus.mem_rd), 32'(e.rd));
    chk({nm, "_wr"}, 32'(bus.mem_wr), 32'(e.wr));
    chk({nm, "_ill"}, 32'(bus.illegal), 32'(e.ill));
    chk({nm, "_halt"}, 32'(bus.halt), 32'(e.hlt));
    chk({nm, "_shamt"}, 32'(bus.shamt), 32'(w[10:6]));
    chk({nm, "_immx"}, bus.imm_ext, 32'($signed(w[15:0])));
    chk({nm, "_rs"}, bus.rs_data, mreg[w[25:21]]);
    chk({nm, "_rt"}, bus.rt_data, mreg[w[20:16]]);
    if (e.we) chk({nm, "_wa"}, 32'(bus.wr_addr), 32'(e.wa));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dv"}, 32'(bus.dec_valid), 32'd0);
    chk({nm, "_halt"}, 32'(bus.halt), 32'd0);
    chk({nm, "_ctl"}, {22'd0, bus.alu_sel, bus.use_imm, bus.reg_we, bus.mem_rd, bus.mem_wr, bus.illegal, 1'b0}, 32'd0);
    chk({nm, "_rs"}, bus.rs_data, 32'd0);
    chk({nm, "_rt"}, bus.rt_data, 32'd0);
    chk({nm, "_immx"}, bus.imm_ext, 32'd0);
    chk({nm, "_wa"}, 32'(bus.wr_addr), 32'd0);
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [31:0] w;
    exp_t e_add;

    ops = '{6'b000000, 6'b000001, 6'b000101, 6'b000110, 6'b000111, 6'b000011,
            6'b000100, 6'b001011, 6'b000010, 6'b100011, 6'b101011, 6'b010101};
    e_add = ex(0, 0, 1, 0, 0, 0, 0, 3);
    vt[0]  = mkv("add",   mk_r(6'b000000, 1, 2, 3, 0),          e_add);
    vt[1]  = mkv("addi",  mk_i(6'b001011, 1, 4, 16'h0004),      ex(0, 1, 1, 0, 0, 0, 0, 4));
    vt[2]  = mkv("lw",    mk_i(6'b100011, 2, 5, 16'hFFF8),      ex(0, 1, 1, 1, 0, 0, 0, 5));
    vt[3]  = mkv("sw",    mk_i(6'b101011, 3, 6, 16'h0004),      ex(0, 1, 0, 0, 1, 0, 0, 0));
    vt[4]  = mkv("sll",   mk_r(6'b000011, 0, 7, 8, 1),          ex(5, 0, 1, 0, 0, 0, 0, 8));
    vt[5]  = mkv("sub",   mk_r(6'b000001, 9, 10, 11, 0),        ex(1, 0, 1, 0, 0, 0, 0, 11));
    vt[6]  = mkv("and",   mk_r(6'b000101, 12, 13, 14, 3),       ex(2, 0, 1, 0, 0, 0, 0, 14));
    vt[7]  = mkv("or",    mk_r(6'b000110, 15, 16, 17, 0),       ex(3, 0, 1, 0, 0, 0, 0, 17));
    vt[8]  = mkv("xor",   mk_r(6'b000111, 18, 19, 20, 0),       ex(4, 0, 1, 0, 0, 0, 0, 20));
    vt[9]  = mkv("srl",   mk_r(6'b000100, 21, 22, 23, 31),      ex(6, 0, 1, 0, 0, 0, 0, 23));
    vt[10] = mkv("li",    mk_i(6'b000010, 24, 25, 16'h8001),    ex(7, 1, 1, 0, 0, 0, 0, 25));
    vt[11] = mkv("illeg", mk_i(6'b010101, 26, 27, 16'h1234),    ex(0, 0, 0, 0, 0, 1, 0, 0));

    bus.instruct = '0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    model_reset();
    #2;
    chk_all_zero("reset");
    step();
    step();
    clr = 1'b0;

    // Before any flush the word is ignored.
    for (int i = 0; i < 12; i++) begin
      bus.instruct = {1'b0, 32'($urandom())};
      step();
      chk("sync_dv", 32'(bus.dec_valid), 32'd0);
    end

    do_flush();
    for (int i = 0; i < 12; i++) issue(vt[i].w, vt[i].e, 1'b0, 5'd0, 32'd0, vt[i].name);

    issue(mk_r(6'b000000, 1, 2, 3, 0), e_add, 1'b1, 5'd1, 32'hDEAD_BEEF, "bypass");
    chk("bypass_val", bus.rs_data, 32'hDEAD_BEEF);
    issue(mk_r(6'b000000, 0, 1, 3, 0), e_add, 1'b1, 5'd0, 32'hFFFF_FFFF, "r0wr");
    chk("r0_val", bus.rs_data, 32'd0);

    // Flush sampled at phase 3 of an illegal word: nothing captured, cadence restarts.
    bus.instruct = {1'b0, mk_i(6'b010101, 1, 2, 16'h0)};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midflush_dv", 32'(bus.dec_valid), 32'd0);
    end
    do_flush();
    issue(mk_r(6'b000000, 4, 5, 3, 0), e_add, 1'b0, 5'd0, 32'd0, "after_flush");

    issue(32'hFFFF_FFFF, ex(0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 5'd0, 32'd0, "halt");
    rnd_wb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.instruct = {1'b0, 32'($urandom())};
      rand_wb();
      step();
      chk("halted_dv", 32'(bus.dec_valid), 32'd0);
      chk("halted_halt", 32'(bus.halt), 32'd1);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0777;
    step();
    rnd_wb = 1'b0;
    do_flush();
    issue(mk_r(6'b000000, 7, 6, 3, 0), e_add, 1'b0, 5'd0, 32'd0, "post_halt");

    rnd_wb = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [4:0] ca;
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 62));
      w = {op, 26'($urandom())};
      ca = ($urandom_range(0, 1) == 1) ? w[25:21] : 5'($urandom());
      issue(w, ref_dec(w), 1'($urandom_range(0, 1)), ca, $urandom(), "rand");
    end
    rnd_wb = 1'b0;

    // Asynchronous clear while halted.
    issue(32'hFFFF_FFFF, ex(0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 5'd0, 32'd0, "halt2");
    #3;
    clr = 1'b1;
    #1;
    chk_all_zero("async_clr");
    model_reset();
    step();
    clr = 1'b0;
    do_flush();
    issue(mk_r(6'b000000, 5, 0, 9, 0), ex(0, 0, 1, 0, 0, 0, 0, 9), 1'b0, 5'd0, 32'd0, "reinit");
    chk("r5_init", bus.rs_data, 32'd5);
    chk("r0_init", bus.rt_data, 32'd0);
    issue(mk_r(6'b000000, 1, 31, 9, 0), ex(0, 0, 1, 0, 0, 0, 0, 9), 1'b0, 5'd0, 32'd0, "reinit2");
    chk("r1_init", bus.rs_data, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
